// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Sequences instruction fetch around the PC register. Chooses the next PC
//   (sequential, branch, jump or trap), runs a req/ready + rvalid handshake
//   with instruction memory, presents the fetched word to decode with stall
//   back-pressure, and kills in-flight fetches when a redirect arrives.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   stall                         decode not ready, hold presented instr
//   branch_taken / branch_target  lowest-priority redirect
//   jump / jump_target            middle-priority redirect
//   trap / trap_vector            highest-priority redirect
//   imem_req, imem_addr           fetch request and word-aligned address
//   imem_ready                    request accepted when imem_req & imem_ready
//   imem_rvalid, imem_rdata       one response per accepted request
//   instr_valid, instr, instr_pc  fetched instruction presented to decode
//   fetch_err                     one-cycle pulse when a fetch times out
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap,
  input  logic [31:0] trap_vector,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          pend_q, pend_d;
  logic          kill_q, kill_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;
  logic          err_q, err_d;

  logic          redirect;
  logic [31:0]   redir_raw;
  logic [31:0]   redir_tgt;

  assign redirect  = trap | jump | branch_taken;
  assign redir_raw = trap ? trap_vector : (jump ? jump_target : branch_target);
  assign redir_tgt = {redir_raw[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VEC;
      pend_pc_q  <= 32'h0;
      pend_q     <= 1'b0;
      kill_q     <= 1'b0;
      timer_q    <= '0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_q     <= pend_d;
      kill_q     <= kill_d;
      timer_q    <= timer_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    pend_d     = pend_q;
    kill_d     = kill_q;
    timer_d    = timer_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = redir_tgt;
      end

      REQ: begin
        if (imem_ready) begin
          state_d = WAIT;
          timer_d = '0;
          pend_d  = 1'b0;
          // The accepted request is already stale if a redirect is live now
          // or was parked while the address had to stay stable.
          if (redirect) begin
            kill_d = 1'b1;
            pc_d   = redir_tgt;
          end else if (pend_q) begin
            kill_d = 1'b1;
            pc_d   = pend_pc_q;
          end
        end else if (redirect) begin
          // Address must not change until accepted: park the target.
          pend_d    = 1'b1;
          pend_pc_d = redir_tgt;
        end
      end

      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (imem_rvalid) begin
          state_d = REQ;
          kill_d  = 1'b0;
          if (redirect) begin
            pc_d = redir_tgt;
          end else if (!kill_q) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = HOLD;
          end
        end else if (timer_q == TIMER_LAST) begin
          // Abandon the request; no response is expected for it any more.
          state_d = REQ;
          err_d   = 1'b1;
          kill_d  = 1'b0;
          if (redirect) pc_d = redir_tgt;
        end else if (redirect) begin
          kill_d = 1'b1;
          pc_d   = redir_tgt;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = redir_tgt;
          state_d = REQ;
        end else if (!stall) begin
          pc_d    = pc_q + 32'd4;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. A small memory responder returns
//   ~addr one cycle after each accepted request when auto_resp is set;
//   otherwise rvalid is driven by hand.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        trap;
  logic [31:0] trap_vector;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_err;

  int vectors     = 0;
  int miscompares = 0;
  bit auto_resp   = 1'b0;

  fetch_sequencer #(.RESET_VEC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .trap(trap), .trap_vector(trap_vector),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      $display("[%0t] ok   %s observed=%h expected=%h", $time, tag, obs, exp);
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; respond to a request accepted on the
  // rising edge in between.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req && imem_ready;
    a   = imem_addr;
    @(negedge clk);
    if (auto_resp) begin
      imem_rvalid = acc;
      imem_rdata  = acc ? ~a : 32'h0;
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    chk({tag, "_req"}, {31'h0, imem_req}, 32'h1);
    chk({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] pc, input logic [31:0] data);
    int n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_instr"}, instr, data);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0;
    trap = 1'b0; trap_vector = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_err", {31'h0, fetch_err}, 32'h0);
    rst = 1'b0;
    auto_resp = 1'b1;

    // 1: back-to-back sequential fetches
    wait_req("seq0", 32'h0);  wait_valid("seq0", 32'h0, 32'hFFFF_FFFF);
    wait_req("seq4", 32'h4);  wait_valid("seq4", 32'h4, 32'hFFFF_FFFB);
    wait_req("seq8", 32'h8);  wait_valid("seq8", 32'h8, 32'hFFFF_FFF7);

    // 2: stall holds the presented instruction
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_pc", instr_pc, 32'h8);
      chk("stall_instr", instr, 32'hFFFF_FFF7);
      chk("stall_noreq", {31'h0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("unstall_addr", imem_addr, 32'hC);
    wait_valid("seqC", 32'hC, 32'hFFFF_FFF3);

    // 3: jump while waiting kills the late response
    auto_resp = 1'b0;
    tick();
    chk("j_req_addr", imem_addr, 32'h10);
    tick();                                  // accepted, now WAIT
    jump = 1'b1; jump_target = 32'h103;      // low bits must be dropped
    tick();
    jump = 1'b0;
    chk("j_wait_valid", {31'h0, instr_valid}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("j_drop_valid", {31'h0, instr_valid}, 32'h0);
    chk("j_new_req", {31'h0, imem_req}, 32'h1);
    chk("j_new_addr", imem_addr, 32'h100);
    auto_resp = 1'b1;
    wait_valid("j100", 32'h100, ~32'h100);

    // 4: trap beats branch in HOLD
    trap = 1'b1; trap_vector = 32'h80;
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    trap = 1'b0; branch_taken = 1'b0;
    chk("t_valid_drop", {31'h0, instr_valid}, 32'h0);
    chk("t_addr", imem_addr, 32'h80);
    wait_valid("t80", 32'h80, ~32'h80);

    // 5: branch during a stalled request is applied after accept
    imem_ready = 1'b0;
    tick();
    chk("b_c1_addr", imem_addr, 32'h84);
    tick();
    chk("b_c2_addr", imem_addr, 32'h84);
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    chk("b_c3_addr", imem_addr, 32'h84);
    tick();
    chk("b_c4_addr", imem_addr, 32'h84);
    tick();
    chk("b_c5_addr", imem_addr, 32'h84);
    imem_ready = 1'b1;
    tick();                                  // accepted, response killed
    chk("b_wait_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("b_kill_valid", {31'h0, instr_valid}, 32'h0);
    chk("b_new_addr", imem_addr, 32'h40);
    wait_valid("b40", 32'h40, ~32'h40);

    // 6: timeout without response, then retry
    auto_resp = 1'b0;
    tick();
    chk("to_req_addr", imem_addr, 32'h44);
    tick();                                  // accepted, timer = 0
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_err", {31'h0, fetch_err}, 32'h0);
    end
    tick();
    chk("to_err_pulse", {31'h0, fetch_err}, 32'h1);
    chk("to_retry_req", {31'h0, imem_req}, 32'h1);
    chk("to_retry_addr", imem_addr, 32'h44);
    tick();
    chk("to_err_clear", {31'h0, fetch_err}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = ~32'h44;
    auto_resp = 1'b1;
    wait_valid("to44", 32'h44, ~32'h44);

    // PC wrap at the top of the address space
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wtop", 32'hFFFF_FFFC, 32'h3);
    wait_req("wrap", 32'h0);
    wait_valid("wrap", 32'h0, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
